// File: rtl/rca_pkg.sv
// rca_pkg: shared parameters, helpers and stage types
// for the pipelined ripple-carry adder/subtractor.
package rca_pkg;

    function automatic bit rca_legal(input int w, input int s);
        return (w > 0) && (s > 0) && (w % s == 0);
    endfunction

    function automatic int seg_w(input int w, input int s);
        return (s > 0) ? w / s : 1;
    endfunction

    typedef struct packed {
        logic v;
        logic c;
    } stg_ctl_t;

endpackage

// File: rtl/rca_seg.sv
// rca_seg: combinational W-bit ripple-carry segment,
// exposing the carry into its MSB for overflow detection.
module rca_seg
    import rca_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         cmsb
);

    logic [W:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < W; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co   = c[W];
    assign cmsb = c[W-1];

endmodule

// File: rtl/rca_pipe.sv
// rca_pipe: STAGES-deep pipelined ripple adder/subtractor
// with valid/ready on both sides and collapsing bubbles.
module rca_pipe
    import rca_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SEG = seg_w(WIDTH, STAGES);
    localparam int N   = STAGES;

    if (!rca_legal(WIDTH, STAGES)) begin : g_bad
        $error("rca_pipe: STAGES must divide WIDTH");
    end

    logic [WIDTH-1:0] bx;
    logic [N-1:0]     vld;
    logic [N-1:0]     adv;
    logic             cm_q;

    assign bx = b ^ {WIDTH{sub}};

    // A stage advances if the consumer takes or any stage at/after it is empty.
    always_comb begin : p_adv
        logic e;
        adv = '0;
        for (int k = 0; k < N; k++) begin
            e = out_ready;
            for (int j = k; j < N; j++) begin
                e = e | ~vld[j];
            end
            adv[k] = e;
        end
    end

    for (genvar k = 0; k < N; k++) begin : g
        localparam int RW = (k + 1) * SEG;

        logic [SEG-1:0] sa;
        logic [SEG-1:0] sb;
        logic [SEG-1:0] s;
        logic           ci;
        logic           co;
        logic           vin;
        logic [RW-1:0]  rin;
        logic [RW-1:0]  res;
        stg_ctl_t       q;

        if (k == 0) begin : g_src
            assign sa  = a[SEG-1:0];
            assign sb  = bx[SEG-1:0];
            assign ci  = sub | cin;
            assign vin = in_valid;
            assign rin = s;
        end else begin : g_src
            assign sa  = g[k-1].g_hi.ah[SEG-1:0];
            assign sb  = g[k-1].g_hi.bh[SEG-1:0];
            assign ci  = g[k-1].q.c;
            assign vin = g[k-1].q.v;
            assign rin = {s, g[k-1].res};
        end

        if (k == N - 1) begin : g_seg
            logic cm_d;
            rca_seg #(.W(SEG)) u_seg (
                .a   (sa),
                .b   (sb),
                .ci  (ci),
                .s   (s),
                .co  (co),
                .cmsb(cm_d)
            );
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cm_q <= 1'b0;
                end else if (adv[k] && vin) begin
                    cm_q <= cm_d;
                end
            end
        end else begin : g_seg
            logic unused_cm;
            rca_seg #(.W(SEG)) u_seg (
                .a   (sa),
                .b   (sb),
                .ci  (ci),
                .s   (s),
                .co  (co),
                .cmsb(unused_cm)
            );
        end

        if (k < N - 1) begin : g_hi
            localparam int HW = WIDTH - RW;
            logic [HW-1:0] an;
            logic [HW-1:0] bn;
            logic [HW-1:0] ah;
            logic [HW-1:0] bh;

            if (k == 0) begin : g_in
                assign an = a[WIDTH-1:SEG];
                assign bn = bx[WIDTH-1:SEG];
            end else begin : g_in
                assign an = g[k-1].g_hi.ah[HW+SEG-1:SEG];
                assign bn = g[k-1].g_hi.bh[HW+SEG-1:SEG];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ah <= '0;
                    bh <= '0;
                end else if (adv[k] && vin) begin
                    ah <= an;
                    bh <= bn;
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                q   <= '0;
                res <= '0;
            end else if (adv[k]) begin
                q.v <= vin;
                if (vin) begin
                    q.c <= co;
                    res <= rin;
                end
            end
        end

        assign vld[k] = q.v;
    end

    assign in_ready  = adv[0];
    assign out_valid = vld[N-1];
    assign sum       = g[N-1].res;
    assign cout      = g[N-1].q.c;
    assign ovf       = cm_q ^ g[N-1].q.c;

endmodule

// File: tb/tb_rca_pipe.sv
// tb_rca_pipe: directed and randomized checks of rca_pipe
// (32/4 and 8/1) against an arithmetic reference model.
module tb_rca_pipe;

    localparam int W = 32;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         sub = 1'b0;
    logic         cin = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    logic         d_in_ready;
    logic         d_out_valid;
    logic [7:0]   d_sum;
    logic         d_cout;
    logic         d_ovf;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rca_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .sub      (sub),
        .cin      (cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    rca_pipe #(.WIDTH(8), .STAGES(1)) u_d8 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (d_in_ready),
        .a        (a[7:0]),
        .b        (b[7:0]),
        .sub      (sub),
        .cin      (cin),
        .out_valid(d_out_valid),
        .out_ready(out_ready),
        .sum      (d_sum),
        .cout     (d_cout),
        .ovf      (d_ovf)
    );

    // Returns {ovf, cout, sum} from plain integer arithmetic.
    function automatic logic [33:0] ref_op(input int w, input logic [31:0] x,
                                           input logic [31:0] y,
                                           input logic s, input logic c);
        longint m, h, ux, uy, sx, sy, u, r;
        logic co, ov;
        m  = longint'(1) << w;
        h  = m >> 1;
        ux = longint'(x) & (m - 1);
        uy = longint'(y) & (m - 1);
        sx = (ux >= h) ? ux - m : ux;
        sy = (uy >= h) ? uy - m : uy;
        if (s) begin
            u  = ux - uy;
            r  = sx - sy;
            co = (ux >= uy);
        end else begin
            u  = ux + uy + longint'(c);
            r  = sx + sy + longint'(c);
            co = (u >= m);
        end
        ov = (r >= h) || (r < -h);
        return {ov, co, 32'(u & (m - 1))};
    endfunction

    logic [31:0] va [5] = '{32'hFFFFFFFF, 32'd5, 32'd7,
                            32'h7FFFFFFF, 32'h80000000};
    logic [31:0] vb [5] = '{32'd1, 32'd7, 32'd5, 32'd1, 32'd1};
    logic        vs [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic        vc [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [33:0] vx [5] = '{{2'b01, 32'h00000000},
                            {2'b00, 32'hFFFFFFFE},
                            {2'b01, 32'h00000002},
                            {2'b10, 32'h80000000},
                            {2'b11, 32'h7FFFFFFF}};

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (sum !== '0) begin
            errors++;
            $display("FAIL reset_sum got=%h exp=0", sum);
        end
        checks++;
        if ({cout, ovf} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=00", {cout, ovf});
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        checks++;
        if (d_out_valid !== 1'b0 || d_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_w8 got=%b%b exp=01", d_out_valid, d_in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_vectors();
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a = va[i];
            b = vb[i];
            sub = vs[i];
            cin = vc[i];
            in_valid = 1'b1;
            @(posedge clk);
            #1 in_valid = 1'b0;
            lat = 0;
            while (!out_valid && lat < 20) begin
                @(posedge clk);
                #1 lat++;
            end
            checks++;
            if (lat !== S - 1) begin
                errors++;
                $display("FAIL vec%0d_latency got=%0d exp=%0d", i, lat, S - 1);
            end
            checks++;
            if ({ovf, cout, sum} !== vx[i]) begin
                errors++;
                $display("FAIL vec%0d_result got=%h exp=%h", i,
                         {ovf, cout, sum}, vx[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] pa [8];
        logic [31:0] pb [8];
        logic        ps [8];
        logic        pc [8];
        logic [33:0] q [$];
        logic [34:0] hold;
        logic [33:0] e;
        bit          have;
        int          acc;
        for (int i = 0; i < 8; i++) begin
            pa[i] = $urandom;
            pb[i] = $urandom;
            ps[i] = 1'($urandom_range(0, 1));
            pc[i] = 1'($urandom_range(0, 1));
        end
        acc = 0;
        have = 0;
        hold = '0;
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            in_valid = (acc < 8);
            a = pa[acc % 8];
            b = pb[acc % 8];
            sub = ps[acc % 8];
            cin = pc[acc % 8];
            #1;
            if (have) begin
                checks++;
                if ({out_valid, ovf, cout, sum} !== hold) begin
                    errors++;
                    $display("FAIL stall_hold got=%h exp=%h",
                             {out_valid, ovf, cout, sum}, hold);
                end
            end
            if (out_valid && !have) begin
                have = 1;
                hold = {out_valid, ovf, cout, sum};
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_op(W, a, b, sub, cin));
                acc++;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (acc !== S) begin
            errors++;
            $display("FAIL stall_accepted got=%0d exp=%0d", acc, S);
        end
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_full got=%b%b exp=01", in_ready, out_valid);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_valid = (acc < 8);
            a = pa[acc % 8];
            b = pb[acc % 8];
            sub = ps[acc % 8];
            cin = pc[acc % 8];
            #1;
            if (c == 0) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL release_in_ready got=%b exp=1", in_ready);
                end
            end
            checks++;
            if (out_valid !== 1'b1 || q.size() == 0) begin
                errors++;
                $display("FAIL stream_gap%0d got=%b exp=1", c, out_valid);
            end else begin
                e = q.pop_front();
                if ({ovf, cout, sum} !== e) begin
                    errors++;
                    $display("FAIL stream%0d got=%h exp=%h", c,
                             {ovf, cout, sum}, e);
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_op(W, a, b, sub, cin));
                acc++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || q.size() != 0 || acc != 8) begin
            errors++;
            $display("FAIL stream_end got=%b/%0d/%0d exp=0/0/8",
                     out_valid, q.size(), acc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_flush();
        int seen;
        int lat;
        logic [33:0] e;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = $urandom;
            b = $urandom;
            sub = 1'b0;
            cin = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_after_rst got=%b%b exp=01", out_valid, in_ready);
        end
        out_ready = 1'b1;
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL flush_ghost got=%0d exp=0", seen);
        end
        a = $urandom;
        b = $urandom;
        sub = 1'b1;
        cin = 1'b0;
        e = ref_op(W, a, b, sub, cin);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        checks++;
        if (lat !== S - 1 || {ovf, cout, sum} !== e) begin
            errors++;
            $display("FAIL flush_new got=%0d/%h exp=%0d/%h", lat,
                     {ovf, cout, sum}, S - 1, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random(input int ncyc);
        logic [33:0] q32 [$];
        logic [33:0] q8 [$];
        logic [34:0] h32, h8;
        logic [33:0] e;
        bit          st32, st8;
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        st32 = 0;
        st8 = 0;
        h32 = '0;
        h8 = '0;
        for (int c = 0; c < ncyc + 40; c++) begin
            in_valid = (c < ncyc) && ($urandom_range(0, 3) != 0);
            out_ready = (c >= ncyc) || ($urandom_range(0, 3) != 0);
            a = $urandom;
            b = $urandom;
            sub = 1'($urandom_range(0, 1));
            cin = 1'($urandom_range(0, 1));
            #4;
            if (st32) begin
                checks++;
                if ({out_valid, ovf, cout, sum} !== h32) begin
                    errors++;
                    $display("FAIL rnd32_hold c=%0d got=%h exp=%h", c,
                             {out_valid, ovf, cout, sum}, h32);
                end
            end
            if (st8) begin
                checks++;
                if ({d_out_valid, d_ovf, d_cout, 24'd0, d_sum} !== h8) begin
                    errors++;
                    $display("FAIL rnd8_hold c=%0d got=%b exp=%h", c,
                             d_out_valid, h8);
                end
            end
            if (in_valid && in_ready) q32.push_back(ref_op(32, a, b, sub, cin));
            if (in_valid && d_in_ready) q8.push_back(ref_op(8, a, b, sub, cin));
            if (out_valid && out_ready) begin
                checks++;
                if (q32.size() == 0) begin
                    errors++;
                    $display("FAIL rnd32_extra c=%0d got=%h exp=none", c, sum);
                end else begin
                    e = q32.pop_front();
                    if ({ovf, cout, sum} !== e) begin
                        errors++;
                        $display("FAIL rnd32 c=%0d got=%h exp=%h", c,
                                 {ovf, cout, sum}, e);
                    end
                end
            end
            if (d_out_valid && out_ready) begin
                checks++;
                if (q8.size() == 0) begin
                    errors++;
                    $display("FAIL rnd8_extra c=%0d got=%h exp=none", c, d_sum);
                end else begin
                    e = q8.pop_front();
                    if ({d_ovf, d_cout, 24'd0, d_sum} !== e) begin
                        errors++;
                        $display("FAIL rnd8 c=%0d got=%h exp=%h", c,
                                 {d_ovf, d_cout, d_sum}, e);
                    end
                end
            end
            st32 = out_valid && !out_ready;
            st8 = d_out_valid && !out_ready;
            h32 = {out_valid, ovf, cout, sum};
            h8 = {d_out_valid, d_ovf, d_cout, 24'd0, d_sum};
            @(posedge clk);
            #1;
        end
        checks++;
        if (q32.size() != 0 || q8.size() != 0) begin
            errors++;
            $display("FAIL rnd_lost got=%0d/%0d exp=0/0", q32.size(), q8.size());
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_flush();
        test_random(3000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
